// File: rtl/battle_pkg.sv
// -----------------------------------------------------------------------------
// battle_pkg
// Shared types and constants for the battle screen turn scheduler.
//   status_t            : phase code driven onto the 4-bit status bus
//   KEY_ENTER           : USB HID keycode used as the confirm key
//   DEF_*               : default HP, damage and phase-length constants
//   satSub()            : 8-bit subtract clamped at zero (9-bit internal math)
// -----------------------------------------------------------------------------
package battle_pkg;

  typedef enum logic [3:0] {
    ST_TITLE      = 4'd0,
    ST_MENU       = 4'd1,
    ST_ATTACK     = 4'd2,
    ST_ENEMY_TEXT = 4'd3,
    ST_PREP       = 4'd4,
    ST_DODGE      = 4'd5,
    ST_WIN        = 4'd6,
    ST_GAMEOVER   = 4'd7
  } status_t;

  localparam logic [7:0] KEY_ENTER = 8'd40;

  localparam logic [7:0] DEF_PLAYER_HP_MAX = 8'd20;
  localparam logic [7:0] DEF_ENEMY_HP_MAX  = 8'd40;
  localparam logic [7:0] DEF_ATTACK_DMG    = 8'd10;
  localparam logic [7:0] DEF_BULLET_DMG    = 8'd4;
  localparam logic [9:0] DEF_ATTACK_FRAMES = 10'd60;
  localparam logic [9:0] DEF_PREP_FRAMES   = 10'd30;
  localparam logic [9:0] DEF_DODGE_FRAMES  = 10'd300;
  localparam logic [9:0] DEF_INVULN_FRAMES = 10'd45;

  // Subtract in 9 bits so a borrow shows up in bit 8; a borrow means the
  // result would have gone negative, so clamp to zero instead of wrapping.
  function automatic logic [7:0] satSub(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] diff;
    diff = {1'b0, a} - {1'b0, b};
    return diff[8] ? 8'd0 : diff[7:0];
  endfunction

endpackage

// File: rtl/battle_sequencer_if.sv
// -----------------------------------------------------------------------------
// battle_sequencer_if
// Bundles the battle sequencer's input events and phase/HP outputs.
//   frame_clk   : vsync-rate frame clock level
//   keycode     : current USB HID keycode, 0 = none
//   hit         : heart/bullet pixel collision
//   status      : phase code (see battle_pkg::status_t)
//   player_hp   : current player HP
//   enemy_hp    : current enemy HP
//   invuln      : high while post-hit invulnerability is running
//   wave_idx    : bullet pattern index for the current/next dodge phase
//   frames_left : ticks remaining in the current timed phase
// master = the side producing events and consuming status (environment),
// slave  = the sequencer itself.
// -----------------------------------------------------------------------------
interface battle_sequencer_if;

  logic       frame_clk;
  logic [7:0] keycode;
  logic       hit;
  logic [3:0] status;
  logic [7:0] player_hp;
  logic [7:0] enemy_hp;
  logic       invuln;
  logic [1:0] wave_idx;
  logic [9:0] frames_left;

  modport master (
    output frame_clk, keycode, hit,
    input  status, player_hp, enemy_hp, invuln, wave_idx, frames_left
  );

  modport slave (
    input  frame_clk, keycode, hit,
    output status, player_hp, enemy_hp, invuln, wave_idx, frames_left
  );

endinterface

// File: rtl/battle_sequencer_frame_tick_det.sv
// -----------------------------------------------------------------------------
// frame_tick_det
// Turns the free-running frame_clk level into a single-Clk tick pulse that
// appears two Clk edges after frame_clk rises.
//   Clk         : system clock
//   Reset       : synchronous, active-low reset
//   frame_clk_i : frame clock level from the video timing block
//   tick_o      : one-Clk pulse per frame_clk rising edge
// -----------------------------------------------------------------------------
module frame_tick_det (
  input  logic Clk,
  input  logic Reset,
  input  logic frame_clk_i,
  output logic tick_o
);

  logic sync_q;
  logic prev_q;
  logic tick_q;

  // First stage samples the frame clock level into the Clk domain, second
  // stage remembers the previous sample; a rising edge is "now high, was low"
  // and is registered so the tick is a clean one-cycle pulse.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= frame_clk_i;
      prev_q <= sync_q;
      tick_q <= sync_q & ~prev_q;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/battle_sequencer.sv
// -----------------------------------------------------------------------------
// battle_sequencer
// Turn scheduler for the battle screen. Steps through menu, attack, enemy
// text, prep and dodge phases on frame ticks and Enter presses, and owns
// player HP, enemy HP, the post-hit invulnerability timer and wave index.
//   Clk   : system clock
//   Reset : synchronous, active-low reset (aborts any phase back to TITLE)
//   bus   : battle_sequencer_if.slave (frame_clk/keycode/hit in,
//           status/player_hp/enemy_hp/invuln/wave_idx/frames_left out)
// -----------------------------------------------------------------------------
module battle_sequencer
  import battle_pkg::*;
#(
  parameter logic [7:0] PLAYER_HP_MAX = DEF_PLAYER_HP_MAX,
  parameter logic [7:0] ENEMY_HP_MAX  = DEF_ENEMY_HP_MAX,
  parameter logic [7:0] ATTACK_DMG    = DEF_ATTACK_DMG,
  parameter logic [7:0] BULLET_DMG    = DEF_BULLET_DMG,
  parameter logic [9:0] ATTACK_FRAMES = DEF_ATTACK_FRAMES,
  parameter logic [9:0] PREP_FRAMES   = DEF_PREP_FRAMES,
  parameter logic [9:0] DODGE_FRAMES  = DEF_DODGE_FRAMES,
  parameter logic [9:0] INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input logic              Clk,
  input logic              Reset,
  battle_sequencer_if.slave bus
);

  status_t    state_q, state_d;
  logic [7:0] playerHp_q, playerHp_d;
  logic [7:0] enemyHp_q, enemyHp_d;
  logic [9:0] invulnCnt_q, invulnCnt_d;
  logic       invuln_q;
  logic [1:0] wave_q, wave_d;
  logic [9:0] frames_q, frames_d;
  logic       hitPending_q, hitPending_d;
  logic [7:0] keyPrev_q;

  logic       tick;
  logic       confirm;
  logic       pendingNow;
  logic       hitAccepted;
  logic [7:0] hpAfterHit;
  logic [7:0] enemyAfterAtk;

  frame_tick_det u_tick (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk_i (bus.frame_clk),
    .tick_o      (tick)
  );

  // A confirm is the first cycle Enter is seen; holding the key keeps
  // keyPrev_q at Enter so it cannot re-trigger.
  assign confirm = (bus.keycode == KEY_ENTER) && (keyPrev_q != KEY_ENTER);

  // All architectural state lives here; reset drops straight back to the
  // title screen with fresh HP and no pending hit or invulnerability.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q      <= ST_TITLE;
      playerHp_q   <= PLAYER_HP_MAX;
      enemyHp_q    <= ENEMY_HP_MAX;
      invulnCnt_q  <= '0;
      invuln_q     <= 1'b0;
      wave_q       <= '0;
      frames_q     <= '0;
      hitPending_q <= 1'b0;
      keyPrev_q    <= '0;
    end else begin
      state_q      <= state_d;
      playerHp_q   <= playerHp_d;
      enemyHp_q    <= enemyHp_d;
      invulnCnt_q  <= invulnCnt_d;
      invuln_q     <= (invulnCnt_d != '0);
      wave_q       <= wave_d;
      frames_q     <= frames_d;
      hitPending_q <= hitPending_d;
      keyPrev_q    <= bus.keycode;
    end
  end

  // Next-state logic. Hit handling runs first so the DODGE branch can see
  // whether this tick's hit drained the player's HP: running out of HP wins
  // over the dodge timer expiring on the same tick. A hit arriving on the
  // tick cycle itself is folded into pendingNow so it is not lost when the
  // tick clears the pending flag.
  always_comb begin
    state_d       = state_q;
    playerHp_d    = playerHp_q;
    enemyHp_d     = enemyHp_q;
    invulnCnt_d   = invulnCnt_q;
    wave_d        = wave_q;
    frames_d      = frames_q;
    hitPending_d  = hitPending_q;
    hitAccepted   = 1'b0;
    hpAfterHit    = playerHp_q;
    enemyAfterAtk = satSub(enemyHp_q, ATTACK_DMG);
    pendingNow    = hitPending_q | (bus.hit && (state_q == ST_DODGE));

    if (pendingNow) begin
      hitPending_d = 1'b1;
    end

    if (tick) begin
      hitPending_d = 1'b0;
      if (invulnCnt_q != '0) begin
        invulnCnt_d = invulnCnt_q - 10'd1;
      end
      if (pendingNow && (invulnCnt_q == '0)) begin
        hitAccepted = 1'b1;
        hpAfterHit  = satSub(playerHp_q, BULLET_DMG);
        playerHp_d  = hpAfterHit;
        invulnCnt_d = INVULN_FRAMES;
      end
    end

    case (state_q)
      ST_TITLE: begin
        playerHp_d   = PLAYER_HP_MAX;
        enemyHp_d    = ENEMY_HP_MAX;
        wave_d       = '0;
        invulnCnt_d  = '0;
        frames_d     = '0;
        hitPending_d = 1'b0;
        if (confirm) begin
          state_d = ST_MENU;
        end
      end
      ST_MENU: begin
        if (confirm) begin
          state_d  = ST_ATTACK;
          frames_d = ATTACK_FRAMES;
        end
      end
      ST_ATTACK: begin
        if (tick) begin
          if (frames_q == 10'd1) begin
            frames_d  = '0;
            enemyHp_d = enemyAfterAtk;
            state_d   = (enemyAfterAtk == '0) ? ST_WIN : ST_ENEMY_TEXT;
          end else begin
            frames_d = frames_q - 10'd1;
          end
        end
      end
      ST_ENEMY_TEXT: begin
        if (confirm) begin
          state_d  = ST_PREP;
          frames_d = PREP_FRAMES;
        end
      end
      ST_PREP: begin
        if (tick) begin
          if (frames_q == 10'd1) begin
            state_d  = ST_DODGE;
            frames_d = DODGE_FRAMES;
          end else begin
            frames_d = frames_q - 10'd1;
          end
        end
      end
      ST_DODGE: begin
        if (tick) begin
          if (hitAccepted && (hpAfterHit == '0)) begin
            state_d  = ST_GAMEOVER;
            frames_d = '0;
          end else if (frames_q == 10'd1) begin
            state_d  = ST_MENU;
            frames_d = '0;
            wave_d   = wave_q + 2'd1;
          end else begin
            frames_d = frames_q - 10'd1;
          end
        end
      end
      ST_WIN, ST_GAMEOVER: begin
        if (confirm) begin
          state_d = ST_TITLE;
        end
      end
      default: begin
        state_d = ST_TITLE;
      end
    endcase

    // A pending hit never survives into another phase.
    if (state_d != state_q) begin
      hitPending_d = 1'b0;
    end
  end

  assign bus.status      = state_q;
  assign bus.player_hp   = playerHp_q;
  assign bus.enemy_hp    = enemyHp_q;
  assign bus.invuln      = invuln_q;
  assign bus.wave_idx    = wave_q;
  assign bus.frames_left = frames_q;

endmodule
